decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_decode_pipe.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - RV instruction decode stage with register file, load-use interlock and ID/EX register (optional DECODE_WB_BYPASS_EN)
module decode_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc_address,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            out_valid,
  output logic            out_load,
  output logic            out_store,
  output logic            out_next_sel,
  output logic            out_branch_result,
  output logic            out_reg_write,
  output logic            out_illegal,
  output logic [3:0]      out_alu_control,
  output logic [1:0]      out_mem_to_reg,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_opa,
  output logic [XLEN-1:0] out_opb,
  output logic [XLEN-1:0] out_opb_data
);

  localparam int IW = $clog2(NREG);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // ALU code 4'b1111 is not reachable from R-type encodings; LUI uses it as "pass operand B"
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  // Writeback source select: ALU result, load data, or return address
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  logic [XLEN-1:0] regs [NREG];

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [2:0] funct3;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];

  // Register index exists in this register file (RV32E has only x0..x15)
  function automatic logic idx_ok(input logic [4:0] idx);
    return ({27'd0, idx} < NREG);
  endfunction

  // Sign-extend a 32-bit quantity to the datapath width
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = sext32({{20{instruction[31]}}, instruction[31:20]});
  assign imm_s = sext32({{20{instruction[31]}}, instruction[31:25], instruction[11:7]});
  assign imm_b = sext32({{19{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0});
  assign imm_u = sext32({instruction[31:12], 12'd0});
  assign imm_j = sext32({{11{instruction[31]}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0});

  logic            known;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            writes_rd;
  logic            is_load;
  logic            is_store;
  logic            is_branch;
  logic            is_jump;
  logic            sel_pc;
  logic            r_type;
  logic [3:0]      alu_ctl;
  logic [1:0]      wb_sel;
  logic [XLEN-1:0] imm;

  // Opcode decode: which fields are live, immediate format and control signals
  always_comb begin
    known     = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    sel_pc    = 1'b0;
    r_type    = 1'b0;
    alu_ctl   = ALU_ADD;
    wb_sel    = WB_ALU;
    imm       = '0;
    case (opcode)
      OP_LUI: begin
        known     = 1'b1;
        writes_rd = 1'b1;
        imm       = imm_u;
        alu_ctl   = ALU_PASSB;
      end
      OP_AUIPC: begin
        known     = 1'b1;
        writes_rd = 1'b1;
        imm       = imm_u;
        sel_pc    = 1'b1;
      end
      OP_JAL: begin
        known     = 1'b1;
        writes_rd = 1'b1;
        imm       = imm_j;
        sel_pc    = 1'b1;
        is_jump   = 1'b1;
        wb_sel    = WB_PC4;
      end
      OP_JALR: begin
        known     = 1'b1;
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        imm       = imm_i;
        is_jump   = 1'b1;
        wb_sel    = WB_PC4;
      end
      OP_BRANCH: begin
        known     = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        imm       = imm_b;
        sel_pc    = 1'b1;
        is_branch = 1'b1;
      end
      OP_LOAD: begin
        known     = 1'b1;
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        imm       = imm_i;
        is_load   = 1'b1;
        wb_sel    = WB_MEM;
      end
      OP_STORE: begin
        known     = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        imm       = imm_s;
        is_store  = 1'b1;
      end
      OP_IMM: begin
        known     = 1'b1;
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        imm       = imm_i;
        // Only the right-shift immediate uses bit 30 to pick arithmetic vs logical
        alu_ctl   = {(funct3 == 3'b101) & instruction[30], funct3};
      end
      OP_REG: begin
        known     = 1'b1;
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        r_type    = 1'b1;
        alu_ctl   = {instruction[30], funct3};
      end
      default: begin
        known = 1'b0;
      end
    endcase
  end

  logic bad_idx;
  logic illegal;

  assign bad_idx = (uses_rs1 && !idx_ok(rs1)) || (uses_rs2 && !idx_ok(rs2)) ||
                   (writes_rd && !idx_ok(rd));
  assign illegal = !known || bad_idx;

  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  // Combinational register reads; x0 and out-of-range indices read as zero
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != 5'd0 && idx_ok(rs1)) rs1_data = regs[rs1[IW-1:0]];
    if (rs2 != 5'd0 && idx_ok(rs2)) rs2_data = regs[rs2[IW-1:0]];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs1 && idx_ok(rs1)) rs1_data = wb_data;
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs2 && idx_ok(rs2)) rs2_data = wb_data;
`endif
  end

  logic lt_s;
  logic lt_u;
  logic cmp;
  logic br_taken;

  assign lt_s = $signed(rs1_data) < $signed(rs2_data);
  assign lt_u = rs1_data < rs2_data;

  // Branch condition selected by funct3; reserved encodings never take
  always_comb begin
    cmp = 1'b0;
    case (funct3)
      3'b000:  cmp = (rs1_data == rs2_data);
      3'b001:  cmp = (rs1_data != rs2_data);
      3'b100:  cmp = lt_s;
      3'b101:  cmp = !lt_s;
      3'b110:  cmp = lt_u;
      3'b111:  cmp = !lt_u;
      default: cmp = 1'b0;
    endcase
  end

  assign br_taken = is_branch && cmp;

  logic hazard;
  logic advance;
  logic accept;

  // Load-use interlock: the load in ID/EX has not produced its data yet
  assign hazard  = out_valid && out_load && (out_rd != 5'd0) &&
                   ((uses_rs1 && out_rd == rs1) || (uses_rs2 && out_rd == rs2));
  assign advance = !out_valid || ex_ready;
  assign in_ready = !rst && advance && !hazard;
  assign accept   = in_valid && in_ready;

  // Register file writes; x0 and indices beyond NREG are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0 && idx_ok(wb_rd)) begin
      regs[wb_rd[IW-1:0]] <= wb_data;
    end
  end

  // ID/EX register: load on accept, bubble when advancing without a new instruction, hold on stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_load          <= 1'b0;
      out_store         <= 1'b0;
      out_next_sel      <= 1'b0;
      out_branch_result <= 1'b0;
      out_reg_write     <= 1'b0;
      out_illegal       <= 1'b0;
      out_alu_control   <= '0;
      out_mem_to_reg    <= '0;
      out_rd            <= '0;
      out_opa           <= '0;
      out_opb           <= '0;
      out_opb_data      <= '0;
    end else if (advance) begin
      if (accept) begin
        out_valid         <= 1'b1;
        out_load          <= is_load && !illegal;
        out_store         <= is_store && !illegal;
        out_next_sel      <= is_jump;
        out_branch_result <= br_taken;
        out_reg_write     <= writes_rd && !illegal && (rd != 5'd0);
        out_illegal       <= illegal;
        out_alu_control   <= alu_ctl;
        out_mem_to_reg    <= wb_sel;
        out_rd            <= rd;
        out_opa           <= sel_pc ? pc_address : rs1_data;
        out_opb           <= r_type ? rs2_data : imm;
        out_opb_data      <= rs2_data;
      end else begin
        out_valid         <= 1'b0;
        out_load          <= 1'b0;
        out_store         <= 1'b0;
        out_next_sel      <= 1'b0;
        out_branch_result <= 1'b0;
        out_reg_write     <= 1'b0;
        out_illegal       <= 1'b0;
        out_alu_control   <= '0;
        out_mem_to_reg    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - table-driven self-checking bench for decode_pipe
module tb_decode_pipe;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JALR = 7'b1100111;
  localparam logic [6:0] LOAD = 7'b0000011, OPI = 7'b0010011, OPR = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] pc_address = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        ex_ready = 1'b0;

  logic        in_ready, out_valid, out_load, out_store, out_next_sel, out_branch_result;
  logic        out_reg_write, out_illegal;
  logic [3:0]  out_alu_control;
  logic [1:0]  out_mem_to_reg;
  logic [4:0]  out_rd;
  logic [31:0] out_opa, out_opb, out_opb_data;

  logic        e_in_ready, e_valid, e_load, e_store, e_next_sel, e_br, e_regw, e_ill;
  logic [3:0]  e_alu;
  logic [1:0]  e_m2r;
  logic [4:0]  e_rd;
  logic [31:0] e_opa, e_opb, e_opbd;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decode_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc_address(pc_address),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready),
    .out_valid(out_valid), .out_load(out_load), .out_store(out_store),
    .out_next_sel(out_next_sel), .out_branch_result(out_branch_result),
    .out_reg_write(out_reg_write), .out_illegal(out_illegal),
    .out_alu_control(out_alu_control), .out_mem_to_reg(out_mem_to_reg),
    .out_rd(out_rd), .out_opa(out_opa), .out_opb(out_opb), .out_opb_data(out_opb_data)
  );

  decode_pipe #(.XLEN(32), .NREG(16)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready),
    .instruction(instruction), .pc_address(pc_address),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready),
    .out_valid(e_valid), .out_load(e_load), .out_store(e_store),
    .out_next_sel(e_next_sel), .out_branch_result(e_br),
    .out_reg_write(e_regw), .out_illegal(e_ill),
    .out_alu_control(e_alu), .out_mem_to_reg(e_m2r),
    .out_rd(e_rd), .out_opa(e_opa), .out_opb(e_opb), .out_opb_data(e_opbd)
  );

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [127:0] exp;
  } vec_t;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, s2, s1, f3, d, OPR};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d,
                                        input logic [6:0] op);
    return {im, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3);
    return {im[11:5], s2, s1, f3, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3);
    return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] d,
                                        input logic [6:0] op);
    return {im, d, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] d);
    return {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
  endfunction

  function automatic logic [127:0] mk(input logic v, input logic l, input logic s,
                                      input logic n, input logic b, input logic w,
                                      input logic i, input logic [3:0] alu,
                                      input logic [1:0] m2r, input logic [4:0] d,
                                      input logic [31:0] a, input logic [31:0] ob,
                                      input logic [31:0] obd);
    return {14'd0, v, l, s, n, b, w, i, alu, m2r, d, a, ob, obd};
  endfunction

  function automatic logic [127:0] got();
    return {14'd0, out_valid, out_load, out_store, out_next_sel, out_branch_result,
            out_reg_write, out_illegal, out_alu_control, out_mem_to_reg, out_rd,
            out_opa, out_opb, out_opb_data};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1;
    wb_rd = r;
    wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  vec_t vecs[18];
  logic [127:0] snap;
  logic [31:0] bypass_exp;

  initial begin
    vecs[0]  = '{"addi_neg",  enc_i(12'hFFF, 5'd6, 3'b000, 5'd3, OPI),
                 mk(1,0,0,0,0,1,0,4'h0,2'd0,5'd3,32'h10,32'hFFFFFFFF,32'h0)};
    vecs[1]  = '{"add",       enc_r(7'h00, 5'd7, 5'd6, 3'b000, 5'd4),
                 mk(1,0,0,0,0,1,0,4'h0,2'd0,5'd4,32'h10,32'h20,32'h20)};
    vecs[2]  = '{"sub",       enc_r(7'h20, 5'd7, 5'd6, 3'b000, 5'd5),
                 mk(1,0,0,0,0,1,0,4'h8,2'd0,5'd5,32'h10,32'h20,32'h20)};
    vecs[3]  = '{"srai",      enc_i(12'h404, 5'd1, 3'b101, 5'd8, OPI),
                 mk(1,0,0,0,0,1,0,4'hD,2'd0,5'd8,32'hFFFFFFFF,32'h404,32'h0)};
    vecs[4]  = '{"lw",        enc_i(12'd8, 5'd6, 3'b010, 5'd9, LOAD),
                 mk(1,1,0,0,0,1,0,4'h0,2'd1,5'd9,32'h10,32'h8,32'h0)};
    vecs[5]  = '{"sw",        enc_s(12'hFFC, 5'd7, 5'd6, 3'b010),
                 mk(1,0,1,0,0,0,0,4'h0,2'd0,5'd28,32'h10,32'hFFFFFFFC,32'h20)};
    vecs[6]  = '{"beq",       enc_b(13'd8, 5'd6, 5'd6, 3'b000),
                 mk(1,0,0,0,1,0,0,4'h0,2'd0,5'd8,32'h100,32'h8,32'h10)};
    vecs[7]  = '{"blt",       enc_b(13'h1FF0, 5'd2, 5'd1, 3'b100),
                 mk(1,0,0,0,1,0,0,4'h0,2'd0,5'd17,32'h100,32'hFFFFFFF0,32'h1)};
    vecs[8]  = '{"bltu",      enc_b(13'h1FF0, 5'd2, 5'd1, 3'b110),
                 mk(1,0,0,0,0,0,0,4'h0,2'd0,5'd17,32'h100,32'hFFFFFFF0,32'h1)};
    vecs[9]  = '{"bge",       enc_b(13'd4, 5'd1, 5'd2, 3'b101),
                 mk(1,0,0,0,1,0,0,4'h0,2'd0,5'd4,32'h100,32'h4,32'hFFFFFFFF)};
    vecs[10] = '{"bne",       enc_b(13'd4, 5'd7, 5'd6, 3'b001),
                 mk(1,0,0,0,1,0,0,4'h0,2'd0,5'd4,32'h100,32'h4,32'h20)};
    vecs[11] = '{"lui",       enc_u(20'h80000, 5'd10, LUI),
                 mk(1,0,0,0,0,1,0,4'hF,2'd0,5'd10,32'h0,32'h80000000,32'h0)};
    vecs[12] = '{"auipc",     enc_u(20'h00001, 5'd11, AUIPC),
                 mk(1,0,0,0,0,1,0,4'h0,2'd0,5'd11,32'h100,32'h1000,32'h0)};
    vecs[13] = '{"jal",       enc_j(21'h800, 5'd1),
                 mk(1,0,0,1,0,1,0,4'h0,2'd2,5'd1,32'h100,32'h800,32'hFFFFFFFF)};
    vecs[14] = '{"jalr_x0",   enc_i(12'd0, 5'd7, 3'b000, 5'd0, JALR),
                 mk(1,0,0,1,0,0,0,4'h0,2'd2,5'd0,32'h20,32'h0,32'h0)};
    vecs[15] = '{"illegal",   32'h000002FF,
                 mk(1,0,0,0,0,0,1,4'h0,2'd0,5'd5,32'h0,32'h0,32'h0)};
    vecs[16] = '{"addi_rd0",  enc_i(12'd1, 5'd0, 3'b000, 5'd0, OPI),
                 mk(1,0,0,0,0,0,0,4'h0,2'd0,5'd0,32'h0,32'h1,32'hFFFFFFFF)};
    vecs[17] = '{"add_x0src", enc_r(7'h00, 5'd1, 5'd0, 3'b000, 5'd12),
                 mk(1,0,0,0,0,1,0,4'h0,2'd0,5'd12,32'h0,32'hFFFFFFFF,32'hFFFFFFFF)};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", got(), 128'd0);
    check("reset_in_ready", {127'd0, in_ready}, 128'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", {127'd0, in_ready}, 128'd1);

    // ADDI x1,x0,5 right after reset
    pc_address = 32'h100;
    ex_ready = 1'b1;
    in_valid = 1'b1;
    instruction = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);
    tick();
    check("addi_after_reset", got(), mk(1,0,0,0,0,1,0,4'h0,2'd0,5'd1,32'h0,32'h5,32'h0));

    // register index beyond the RV32E file
    instruction = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd20);
    tick();
    check("nreg16_x20", {125'd0, e_valid, e_ill, e_regw}, {125'd0, 3'b110});
    check("nreg32_x20", {125'd0, out_valid, out_illegal, out_reg_write}, {125'd0, 3'b101});
    in_valid = 1'b0;

    // preload registers; the x0 write must be dropped
    wb_write(5'd1, 32'hFFFFFFFF);
    wb_write(5'd2, 32'h1);
    wb_write(5'd6, 32'h10);
    wb_write(5'd7, 32'h20);
    wb_write(5'd0, 32'h12345678);

    for (int i = 0; i < 18; i++) begin
      instruction = vecs[i].ins;
      in_valid = 1'b1;
      tick();
      check(vecs[i].name, got(), vecs[i].exp);
    end
    in_valid = 1'b0;
    tick();

    // load-use: LW x2 then ADD x3,x2,x2 -> one bubble
    in_valid = 1'b1;
    instruction = enc_i(12'd0, 5'd0, 3'b010, 5'd2, LOAD);
    tick();
    check("lw_issue", {120'd0, out_valid, out_load, out_rd, 1'b0}, {120'd0, 1'b1, 1'b1, 5'd2, 1'b0});
    instruction = enc_r(7'h00, 5'd2, 5'd2, 3'b000, 5'd3);
    #1;
    check("hazard_in_ready", {127'd0, in_ready}, 128'd0);
    @(posedge clk);
    #1;
    check("bubble", {125'd0, out_valid, out_load, in_ready}, {125'd0, 3'b001});
    tick();
    check("add_after_bubble", {64'd0, 26'd0, out_valid, out_rd, out_opa}, {90'd0, 1'b1, 5'd3, 32'h1});
    in_valid = 1'b0;
    tick();

    // execute stall for 3 cycles
    in_valid = 1'b1;
    instruction = enc_i(12'd7, 5'd6, 3'b000, 5'd13, OPI);
    tick();
    snap = mk(1,0,0,0,0,1,0,4'h0,2'd0,5'd13,32'h10,32'h7,32'h20);
    check("stall_first", got(), snap);
    ex_ready = 1'b0;
    instruction = enc_i(12'd9, 5'd0, 3'b000, 5'd14, OPI);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_in_ready", {127'd0, in_ready}, 128'd0);
      tick();
      check("stall_hold", got(), snap);
    end
    ex_ready = 1'b1;
    #1;
    check("release_in_ready", {127'd0, in_ready}, 128'd1);
    tick();
    check("release_issue", {96'd0, 27'd0, out_rd}, {123'd0, 5'd14});

    // reset during a stall drops the pending instruction
    ex_ready = 1'b0;
    instruction = enc_i(12'd3, 5'd0, 3'b000, 5'd15, OPI);
    tick();
    check("stall_before_reset", {122'd0, out_valid, out_rd}, {122'd0, 1'b1, 5'd14});
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", got(), 128'd0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    ex_ready = 1'b1;
    tick();
    tick();
    check("no_replay", {127'd0, out_valid}, 128'd0);
    in_valid = 1'b1;
    instruction = enc_r(7'h00, 5'd6, 5'd7, 3'b000, 5'd16);
    tick();
    check("regfile_cleared", {64'd0, out_opa, out_opb}, 128'd0);
    in_valid = 1'b0;
    tick();

    // writeback in the same cycle as a dependent read
`ifdef DECODE_WB_BYPASS_EN
    bypass_exp = 32'hDEADBEEF;
`else
    bypass_exp = 32'h0;
`endif
    wb_en = 1'b1;
    wb_rd = 5'd4;
    wb_data = 32'hDEADBEEF;
    in_valid = 1'b1;
    instruction = enc_r(7'h00, 5'd0, 5'd4, 3'b000, 5'd5);
    tick();
    wb_en = 1'b0;
    check("wb_same_cycle", {96'd0, out_opa}, {96'd0, bypass_exp});
    tick();
    check("wb_next_cycle", {96'd0, out_opa}, {96'd0, 32'hDEADBEEF});
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
